// File: rtl/xmt_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xmt_arbiter_pkg
// Brief    : Shared FSM encoding, index width and helpers for xmt_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package xmt_arbiter_pkg;

    localparam int IDX_W    = 3;
    localparam int NREQ_MAX = 8;
    localparam int STATE_W  = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SEND    = 2'd1;
    localparam state_t ST_SETTLE  = 2'd2;
    localparam state_t ST_WAITRDY = 2'd3;

    function automatic logic [IDX_W-1:0] idx_of(input int i);
        return IDX_W'(i);
    endfunction

endpackage
`default_nettype wire

// File: rtl/xmt_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : xmt_rr_pick
// Brief    : Combinational round-robin picker; first valid index after last_idx.
// Revision : 1.0 - initial release
// ============================================================================
module xmt_rr_pick
    import xmt_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    // Two passes: indices above last_idx first, then wrap to those at or below it.
    always_comb begin
        win_idx = last_idx;
        any     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && valid[i] && (idx_of(i) > last_idx)) begin
                any     = 1'b1;
                win_idx = idx_of(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any && valid[i] && (idx_of(i) <= last_idx)) begin
                any     = 1'b1;
                win_idx = idx_of(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/xmt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xmt_arbiter
// Brief    : Round-robin byte arbiter feeding a transmitter buffer, one byte
//            per IDLE/SEND/SETTLE/WAITRDY cycle.
// Config   : define XMT_ARBITER_LOCK_EN to hold the grant until req_last.
// Revision : 1.0 - initial release
// ============================================================================
module xmt_arbiter
    import xmt_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ack,
    output logic              tx_write,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_gnt_idx;
    logic [IDX_W-1:0]  w_gnt_nxt;
    logic [IDX_W-1:0]  w_win_idx;
    logic [NREQ-1:0]   w_mask;
    logic [NREQ-1:0]   w_win_onehot;
    logic [NREQ-1:0]   r_req_ack;
    logic [NREQ-1:0]   w_ack_nxt;
    logic [7:0]        w_win_byte;
    logic [7:0]        r_tx_data;
    logic [7:0]        w_data_nxt;
    logic              r_tx_write;
    logic              w_write_nxt;
    logic              w_any;
    logic              w_go;

    xmt_rr_pick #(
        .NREQ     (NREQ)
    ) u_pick (
        .valid    (w_mask),
        .last_idx (r_gnt_idx),
        .win_idx  (w_win_idx),
        .any      (w_any)
    );

    always_comb begin
        w_win_byte   = 8'd0;
        w_win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_win_onehot[i] = (w_win_idx == idx_of(i));
            if (w_win_idx == idx_of(i)) begin
                w_win_byte = req_data[i*8 +: 8];
            end
        end
    end

`ifdef XMT_ARBITER_LOCK_EN
    logic              r_locked;
    logic [IDX_W-1:0]  r_lock_idx;
    logic [NREQ-1:0]   w_lock_onehot;
    logic              w_win_last;

    always_comb begin
        w_lock_onehot = '0;
        w_win_last    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            w_lock_onehot[i] = (r_lock_idx == idx_of(i));
            if (w_win_idx == idx_of(i)) begin
                w_win_last = req_last[i];
            end
        end
    end

    // While locked only the owning requester is visible to the picker.
    assign w_mask = r_locked ? (req_valid & w_lock_onehot) : req_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_go) begin
            r_locked   <= ~w_win_last;
            r_lock_idx <= w_win_idx;
        end
    end
`else
    logic w_unused_last;

    assign w_mask        = req_valid;
    assign w_unused_last = ^req_last;
`endif

    assign w_go = (r_state == ST_IDLE) && w_any && tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_go) w_state_nxt = ST_SEND;
            ST_SEND:    w_state_nxt = ST_SETTLE;
            ST_SETTLE:  w_state_nxt = ST_WAITRDY;
            ST_WAITRDY: if (tx_ready) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Next-value logic for the registered outputs; they become visible in SEND.
    always_comb begin
        w_write_nxt = w_go;
        w_ack_nxt   = w_go ? w_win_onehot : '0;
        w_data_nxt  = w_go ? w_win_byte   : r_tx_data;
        w_gnt_nxt   = w_go ? w_win_idx    : r_gnt_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_write <= 1'b0;
            r_req_ack  <= '0;
            r_tx_data  <= 8'd0;
            r_gnt_idx  <= idx_of(NREQ - 1);
        end else begin
            r_tx_write <= w_write_nxt;
            r_req_ack  <= w_ack_nxt;
            r_tx_data  <= w_data_nxt;
            r_gnt_idx  <= w_gnt_nxt;
        end
    end

    assign tx_write = r_tx_write;
    assign req_ack  = r_req_ack;
    assign tx_data  = r_tx_data;
    assign gnt_idx  = r_gnt_idx;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/xmt_arbiter.md
XMT_ARBITER -- requirements
Module: xmt_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 clk  in  1  system clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  NREQ  requester i has a byte pending on req_data[8i+7:8i].
REQ-005 req_data  in  8*NREQ  packed byte per requester.
REQ-006 req_last  in  NREQ  byte of requester i ends its message.
REQ-007 req_ack  out  NREQ  one-cycle pulse: byte of requester i taken.
REQ-008 tx_write  out  1  one-cycle write strobe to the transmitter buffer.
REQ-009 tx_data  out  8  byte to the transmitter buffer, valid while tx_write=1.
REQ-010 tx_ready  in  1  transmitter buffer can accept a byte.
REQ-011 gnt_idx  out  3  index of the last granted requester.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 FSM states: IDLE, SEND, SETTLE, WAITRDY.
REQ-014 IDLE -> SEND when |req_valid and tx_ready both sampled 1; winner latched this edge.
REQ-015 Winner: round-robin, searching from (gnt_idx+1) mod NREQ upward, wrapping; first valid wins.
REQ-016 SEND lasts exactly 1 cycle: tx_write=1, tx_data=latched winner byte, req_ack[winner]=1; next state SETTLE.
REQ-017 SETTLE lasts exactly 1 cycle unconditionally, ignoring tx_ready (covers buffer ready-drop latency).
REQ-018 WAITRDY -> IDLE on tx_ready=1; otherwise hold.
REQ-019 Minimum spacing between tx_write pulses: 4 cycles (IDLE, SEND, SETTLE, WAITRDY).
REQ-020 tx_data, tx_write, req_ack registered; no combinational path from req_* or tx_ready to outputs.
REQ-021 Requester must hold req_valid/req_data/req_last stable until its req_ack; data sampled at the IDLE->SEND edge.
REQ-022 Dropping req_valid before ack: byte not sent unless already latched at the IDLE->SEND edge.
REQ-023 No valid requesters in IDLE: stay IDLE, gnt_idx unchanged.
REQ-024 gnt_idx updated only on a grant; wraps NREQ-1 -> 0.
REQ-025 Only one req_ack bit high in any cycle; req_ack never high outside SEND.

Reset
REQ-026 Reset forces IDLE, tx_write=0, tx_data=0, req_ack=0, gnt_idx=NREQ-1 (first search starts at 0), busy=0, lock cleared.
REQ-027 Reset mid-SEND/SETTLE/WAITRDY abandons the cycle; no further tx_write or req_ack until reset deasserted and IDLE conditions met.

Configuration
REQ-028 Macro XMT_ARBITER_LOCK_EN defined: after granting requester i with req_last[i]=0, lock on i; IDLE grants only i until a byte with req_last[i]=1 is acked; other requests wait.
REQ-029 Locked and req_valid[i]=0: arbiter stays IDLE, emits nothing.
REQ-030 Macro undefined: req_last ignored, pure per-byte round-robin, no lock register.

Structure
REQ-031 Shared package: FSM state encoding, IDX_W=3, NREQ_MAX=8.
REQ-032 One sub-module xmt_rr_pick: combinational round-robin picker (valid mask, last index -> winner index, any flag).

Verification
REQ-033 Req 0 valid data 0x41, tx_ready=1 -> tx_write pulse with tx_data=0x41 one cycle after IDLE sample, req_ack[0] same cycle, gnt_idx=0.
REQ-034 All 4 valid (0x10,0x11,0x12,0x13), held -> bytes sent 0x10,0x11,0x12,0x13,0x10 in order, each pulse 4 cycles apart.
REQ-035 tx_ready held 0 for 20 cycles after SEND -> no tx_write, busy=1, state WAITRDY; tx_ready=1 -> next grant 2 cycles later.
REQ-036 LOCK_EN: req 1 sends 0x20(last=0),0x21(last=1) while req 2 valid 0x30 -> order 0x20,0x21,0x30; without macro 0x20,0x30,0x21.
REQ-037 Reset asserted in SETTLE -> next cycle IDLE, req_ack=0, tx_write=0, gnt_idx=3; next grant goes to requester 0.
